// File: rtl/vectadd_pkg.sv
// Shared vector-add definitions: FSM states, handshake codes and the job record.
// Also used by ACC_Control on the accelerator side of the to_hw/to_sw handshake.
package vectadd_pkg;

    localparam int ADDR_W = 14;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PUT,
        ST_WAIT_TAKEN,
        ST_WAIT_RELEASE,
        ST_WAIT_DONE,
        ST_ACK,
        ST_WAIT_CLEAR
    } state_t;

    // Master -> accelerator (to_hw_sig)
    localparam logic [1:0] HW_IDLE     = 2'b00;
    localparam logic [1:0] HW_WORD_VLD = 2'b01;
    localparam logic [1:0] HW_DONE_ACK = 2'b10;

    // Accelerator -> master (to_sw_sig)
    localparam logic [1:0] SW_IDLE       = 2'b00;
    localparam logic [1:0] SW_WORD_TAKEN = 2'b01;
    localparam logic [1:0] SW_JOB_DONE   = 2'b10;

    typedef struct packed {
        logic [31:0]       len;
        logic [ADDR_W-1:0] addr_a;
        logic [ADDR_W-1:0] addr_b;
        logic [ADDR_W-1:0] addr_s;
    } job_t;

    // Command word sent at position idx; addresses are zero-extended.
    function automatic logic [31:0] cmd_word(input job_t job, input logic [1:0] idx);
        logic [31:0] word;
        case (idx)
            2'd0:    word = {{(32-ADDR_W){1'b0}}, job.addr_a};
            2'd1:    word = {{(32-ADDR_W){1'b0}}, job.addr_b};
            2'd2:    word = {{(32-ADDR_W){1'b0}}, job.addr_s};
            default: word = job.len;
        endcase
        return word;
    endfunction

endpackage

// File: rtl/vectadd_cmd_master.sv
// Sends addr_a, addr_b, addr_s, len over a 2-bit four-phase handshake, then acknowledges job done.
// All outputs registered; every wait state is bounded by TIMEOUT_CYCLES, after which the job aborts with error.
module vectadd_cmd_master
    import vectadd_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [31:0]       len,
    input  logic [ADDR_W-1:0] addr_a,
    input  logic [ADDR_W-1:0] addr_b,
    input  logic [ADDR_W-1:0] addr_s,
    output logic [31:0]       to_hw_data,
    output logic [1:0]        to_hw_sig,
    input  logic [1:0]        to_sw_sig,
    output logic              busy,
    output logic              done,
    output logic              error
);

    localparam int               CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t            state, state_nxt;
    job_t              job, job_nxt;
    logic [1:0]        idx, idx_nxt;
    logic [CNT_W-1:0]  cnt, cnt_nxt;
    logic [31:0]       data_nxt;
    logic [1:0]        sig_nxt;
    logic              done_nxt;
    logic              error_nxt;
    logic              waiting;

    assign busy = (state != ST_IDLE);

    always_comb begin
        state_nxt = state;
        job_nxt   = job;
        idx_nxt   = idx;
        data_nxt  = to_hw_data;
        sig_nxt   = to_hw_sig;
        done_nxt  = 1'b0;
        error_nxt = error;
        waiting   = 1'b0;

        case (state)
            ST_IDLE: begin
                if (start) begin
                    job_nxt.len    = len;
                    job_nxt.addr_a = addr_a;
                    job_nxt.addr_b = addr_b;
                    job_nxt.addr_s = addr_s;
                    idx_nxt        = 2'd0;
                    error_nxt      = 1'b0;
                    state_nxt      = ST_PUT;
                end
            end
            ST_PUT: begin
                data_nxt  = cmd_word(job, idx);
                sig_nxt   = HW_WORD_VLD;
                state_nxt = ST_WAIT_TAKEN;
            end
            ST_WAIT_TAKEN: begin
                waiting = 1'b1;
                if (to_sw_sig == SW_WORD_TAKEN) begin
                    sig_nxt   = HW_IDLE;
                    state_nxt = ST_WAIT_RELEASE;
                end
            end
            ST_WAIT_RELEASE: begin
                waiting = 1'b1;
                if (to_sw_sig == SW_IDLE) begin
                    if (idx == 2'd3) begin
                        state_nxt = ST_WAIT_DONE;
                    end else begin
                        idx_nxt   = idx + 2'd1;
                        state_nxt = ST_PUT;
                    end
                end
            end
            ST_WAIT_DONE: begin
                waiting = 1'b1;
                if (to_sw_sig == SW_JOB_DONE) begin
                    state_nxt = ST_ACK;
                end
            end
            ST_ACK: begin
                sig_nxt   = HW_DONE_ACK;
                state_nxt = ST_WAIT_CLEAR;
            end
            ST_WAIT_CLEAR: begin
                waiting = 1'b1;
                if (to_sw_sig == SW_IDLE) begin
                    sig_nxt   = HW_IDLE;
                    done_nxt  = 1'b1;
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase

        // A match on the last allowed cycle still wins over the abort.
        if (waiting && (state_nxt == state) && (cnt == CNT_LAST)) begin
            sig_nxt   = HW_IDLE;
            error_nxt = 1'b1;
            state_nxt = ST_IDLE;
        end

        if (state_nxt != state) begin
            cnt_nxt = '0;
        end else if (waiting) begin
            cnt_nxt = cnt + CNT_W'(1);
        end else begin
            cnt_nxt = cnt;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            job        <= '0;
            idx        <= 2'd0;
            cnt        <= '0;
            to_hw_data <= 32'd0;
            to_hw_sig  <= HW_IDLE;
            done       <= 1'b0;
            error      <= 1'b0;
        end else begin
            state      <= state_nxt;
            job        <= job_nxt;
            idx        <= idx_nxt;
            cnt        <= cnt_nxt;
            to_hw_data <= data_nxt;
            to_hw_sig  <= sig_nxt;
            done       <= done_nxt;
            error      <= error_nxt;
        end
    end

endmodule

// File: tb/tb_vectadd_cmd_master.sv
// Scoreboarded bench: a responder models the accelerator, a monitor pops expected words/completions.
module tb_vectadd_cmd_master;
    import vectadd_pkg::*;

    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [31:0] len = 32'd0;
    logic [13:0] addr_a = 14'd0, addr_b = 14'd0, addr_s = 14'd0;
    logic [31:0] to_hw_data;
    logic [1:0]  to_hw_sig;
    logic [1:0]  to_sw_sig;
    logic        busy, done, error;

    vectadd_cmd_master #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .reset(reset), .start(start), .len(len),
        .addr_a(addr_a), .addr_b(addr_b), .addr_s(addr_s),
        .to_hw_data(to_hw_data), .to_hw_sig(to_hw_sig), .to_sw_sig(to_sw_sig),
        .busy(busy), .done(done), .error(error)
    );

    always #5 clk = ~clk;

    int n_vec = 0, n_err = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    // Scoreboard: expected words in send order, one entry per expected completion.
    logic [31:0] exp_words[$];
    int          exp_done[$];

    task automatic push_words(input logic [13:0] a, b, s, input logic [31:0] l, input int n);
        logic [31:0] w[4];
        w[0] = {18'd0, a};
        w[1] = {18'd0, b};
        w[2] = {18'd0, s};
        w[3] = l;
        for (int i = 0; i < n; i++) exp_words.push_back(w[i]);
    endtask

    task automatic push_job(input logic [13:0] a, b, s, input logic [31:0] l);
        push_words(a, b, s, l, 4);
        exp_done.push_back(1);
    endtask

    // Monitor
    int          words_seen = 0, done_cnt = 0, vld_len = 0, last_vld_len = 0;
    int          w0_idx = -1, w0_len = 0;
    logic [31:0] cur_word = 32'd0;
    logic [1:0]  prev_sig = 2'b00;
    logic        prev_done = 1'b0;

    initial begin
        forever begin
            @(negedge clk);
            if (reset) begin
                prev_sig  = 2'b00;
                prev_done = 1'b0;
                vld_len   = 0;
            end else begin
                if (to_hw_sig == HW_WORD_VLD) begin
                    if (prev_sig != HW_WORD_VLD) begin
                        words_seen++;
                        vld_len = 0;
                        if (exp_words.size() == 0) begin
                            n_vec++;
                            n_err++;
                            $display("FAIL unexpected_word: got 0x%0h, expected none", to_hw_data);
                            cur_word = to_hw_data;
                        end else begin
                            cur_word = exp_words.pop_front();
                            check("word", to_hw_data, cur_word);
                        end
                    end else begin
                        check("word_stable", to_hw_data, cur_word);
                    end
                    vld_len++;
                end else if (prev_sig == HW_WORD_VLD) begin
                    last_vld_len = vld_len;
                    if (words_seen == w0_idx) w0_len = vld_len;
                end
                if (done) begin
                    done_cnt++;
                    check("done_one_cycle", 32'(prev_done), 32'd0);
                    if (exp_done.size() == 0) begin
                        n_vec++;
                        n_err++;
                        $display("FAIL unexpected_done: got done=1, expected none");
                    end else begin
                        void'(exp_done.pop_front());
                        check("done_error", 32'(error), 32'd0);
                        check("done_sig", 32'(to_hw_sig), 32'(HW_IDLE));
                        check("done_busy", 32'(busy), 32'd0);
                    end
                end
                prev_sig  = to_hw_sig;
                prev_done = done;
            end
        end
    end

    // Accelerator responder
    typedef enum logic [1:0] {PH_VLD, PH_REL, PH_DONE, PH_ACK} ph_t;
    ph_t ph = PH_VLD;
    int  r_words = 0, r_wait = 0, bad_done = 0;
    int  rdelay = 2, cfg_bad = 0, mute_word = -1;
    bit  hold_done = 1'b0, rsp_clear = 1'b0;

    initial begin
        to_sw_sig = SW_IDLE;
        forever begin
            @(posedge clk);
            if (reset || rsp_clear) begin
                ph = PH_VLD; r_words = 0; r_wait = 0; bad_done = 0;
                to_sw_sig <= SW_IDLE;
            end else begin
                case (ph)
                    PH_VLD: if (to_hw_sig == HW_WORD_VLD && r_words != mute_word) begin
                        if (r_words == 0 && bad_done < cfg_bad) begin
                            to_sw_sig <= 2'b11;
                            bad_done++;
                        end else begin
                            r_wait++;
                            if (r_wait >= rdelay) begin
                                r_wait = 0; to_sw_sig <= SW_WORD_TAKEN; ph = PH_REL;
                            end
                        end
                    end
                    PH_REL: if (to_hw_sig == HW_IDLE) begin
                        r_wait++;
                        if (r_wait >= rdelay) begin
                            r_wait = 0; to_sw_sig <= SW_IDLE; r_words++;
                            ph = (r_words == 4) ? PH_DONE : PH_VLD;
                        end
                    end
                    PH_DONE: begin
                        r_wait++;
                        if (r_wait >= rdelay && !hold_done) begin
                            r_wait = 0; to_sw_sig <= SW_JOB_DONE; ph = PH_ACK;
                        end
                    end
                    PH_ACK: if (to_hw_sig == HW_DONE_ACK) begin
                        r_wait++;
                        if (r_wait >= rdelay) begin
                            r_wait = 0; to_sw_sig <= SW_IDLE; r_words = 0; bad_done = 0; ph = PH_VLD;
                        end
                    end
                    default: ph = PH_VLD;
                endcase
            end
        end
    end

    task automatic issue(input logic [13:0] a, b, s, input logic [31:0] l);
        @(negedge clk);
        addr_a = a; addr_b = b; addr_s = s; len = l; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        addr_a = 14'($urandom); addr_b = 14'($urandom); addr_s = 14'($urandom); len = $urandom;
        check("busy_after_start", 32'(busy), 32'd1);
        check("error_clear_on_start", 32'(error), 32'd0);
    endtask

    task automatic wait_done(input string name, input int base);
        int n = 0;
        while (done_cnt == base && n < 400) begin
            @(negedge clk);
            n++;
        end
        check(name, 32'(done_cnt - base), 32'd1);
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while (busy && n < budget) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic check_zero_outputs(input string name);
        check({name, "_sig"},   32'(to_hw_sig), 32'd0);
        check({name, "_data"},  to_hw_data,     32'd0);
        check({name, "_busy"},  32'(busy),      32'd0);
        check({name, "_done"},  32'(done),      32'd0);
        check({name, "_error"}, 32'(error),     32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no end of run, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int base, wbase;
        logic [13:0] ra, rb, rs;
        logic [31:0] rl;

        repeat (2) @(negedge clk);
        check_zero_outputs("reset");
        reset = 1'b0;

        // Basic job, 2-cycle responder
        rdelay = 2;
        base = done_cnt;
        push_job(14'h0010, 14'h0100, 14'h0200, 32'd8);
        issue(14'h0010, 14'h0100, 14'h0200, 32'd8);
        wait_done("basic_done", base);
        check("basic_error", 32'(error), 32'd0);

        // Start during word 2 must be ignored
        base = done_cnt;
        wbase = words_seen;
        push_job(14'h0aaa, 14'h1555, 14'h2222, 32'd77);
        issue(14'h0aaa, 14'h1555, 14'h2222, 32'd77);
        for (int n = 0; n < 200 && words_seen < wbase + 3; n++) @(negedge clk);
        check("reach_word2", 32'(words_seen - wbase), 32'd3);
        addr_a = 14'h3fff; addr_b = 14'h0001; addr_s = 14'h0002; len = 32'hffff_ffff;
        start = 1'b1;
        repeat (2) @(negedge clk);
        start = 1'b0;
        check("busy_ignore_start", 32'(busy), 32'd1);
        wait_done("ignore_done", base);
        repeat (20) @(negedge clk);
        check("ignore_single_done", 32'(done_cnt - base), 32'd1);
        check("ignore_no_extra_words", 32'(exp_words.size()), 32'd0);

        // Unexpected 11 for three cycles before word 0 is taken
        cfg_bad = 3;
        base = done_cnt;
        w0_idx = words_seen + 1;
        push_job(14'h0123, 14'h0456, 14'h0789, 32'd3);
        issue(14'h0123, 14'h0456, 14'h0789, 32'd3);
        wait_done("bad_code_done", base);
        check("bad_code_word0_hold", 32'(w0_len), 32'd6);
        cfg_bad = 0;

        // Responder never takes word 1 -> timeout
        mute_word = 1;
        base = done_cnt;
        push_words(14'h0040, 14'h0050, 14'h0060, 32'd9, 2);
        issue(14'h0040, 14'h0050, 14'h0060, 32'd9);
        wait_idle(200);
        check("timeout_busy", 32'(busy), 32'd0);
        check("timeout_error", 32'(error), 32'd1);
        check("timeout_sig", 32'(to_hw_sig), 32'(HW_IDLE));
        check("timeout_wait_cycles", 32'(last_vld_len), 32'(TO));
        check("timeout_no_done", 32'(done_cnt - base), 32'd0);
        check("timeout_words_sent", 32'(exp_words.size()), 32'd0);
        mute_word = -1;
        @(negedge clk); rsp_clear = 1'b1;
        @(negedge clk); rsp_clear = 1'b0;

        // Next job clears the sticky error (checked in issue)
        base = done_cnt;
        push_job(14'h0001, 14'h0002, 14'h0003, 32'd4);
        issue(14'h0001, 14'h0002, 14'h0003, 32'd4);
        wait_done("after_timeout_done", base);

        // Reset while waiting for job done
        hold_done = 1'b1;
        push_words(14'h3fff, 14'h1234, 14'h0abc, 32'hdead_beef, 4);
        issue(14'h3fff, 14'h1234, 14'h0abc, 32'hdead_beef);
        for (int n = 0; n < 200 && ph != PH_DONE; n++) @(negedge clk);
        repeat (3) @(negedge clk);
        check("busy_in_wait_done", 32'(busy), 32'd1);
        #1 reset = 1'b1;
        #1 check_zero_outputs("midjob_reset");
        hold_done = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        base = done_cnt;
        push_job(14'h0777, 14'h0888, 14'h0999, 32'd16);
        addr_a = 14'h0777; addr_b = 14'h0888; addr_s = 14'h0999; len = 32'd16; start = 1'b1;
        @(posedge clk);
        #1 check("start_first_edge", 32'(busy), 32'd1);
        @(negedge clk);
        start = 1'b0;
        wait_done("post_reset_done", base);

        // Randomized jobs, with occasional ignored start pulses
        for (int i = 0; i < 24; i++) begin
            ra = 14'($urandom); rb = 14'($urandom); rs = 14'($urandom);
            rl = (i == 0) ? 32'd0 : $urandom;
            rdelay = $urandom_range(1, 4);
            base = done_cnt;
            push_job(ra, rb, rs, rl);
            issue(ra, rb, rs, rl);
            if ($urandom_range(0, 1) == 1) begin
                repeat ($urandom_range(1, 10)) @(negedge clk);
                if (busy) begin
                    addr_a = 14'($urandom); len = $urandom; start = 1'b1;
                    @(negedge clk);
                    start = 1'b0;
                end
            end
            wait_done("rand_done", base);
        end

        repeat (10) @(negedge clk);
        check("final_words_drained", 32'(exp_words.size()), 32'd0);
        check("final_done_drained", 32'(exp_done.size()), 32'd0);
        check("final_idle", 32'(busy), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
